// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, opcodes
// and the immediate ranges each format can represent.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational packer: scatters fields and immediate bits into a 32-bit
// instruction word and flags immediates the chosen format cannot hold.
module imm_packer
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm32,
  output logic [31:0] instr,
  output logic        illegal
);

  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        instr   = {imm32[11:0], rs1, funct3, rd, opcode};
        illegal = !in_range(imm32, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        instr   = {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode};
        illegal = !in_range(imm32, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        instr   = {imm32[12], imm32[10:5], rs2, rs1, funct3, imm32[4:1], imm32[11], opcode};
        illegal = !in_range(imm32, IMM13_MIN, IMM13_MAX) || imm32[0];
      end
      FMT_U: begin
        instr   = {imm32[31:12], rd, opcode};
        illegal = (imm32[11:0] != 12'd0);
      end
      FMT_J: begin
        instr   = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd, opcode};
        illegal = !in_range(imm32, IMM21_MIN, IMM21_MAX) || imm32[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: one-deep output register with handshake,
// word-address counter and a saturating count of dropped illegal requests.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm32,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_cnt
);

  logic [31:0]       packed_instr;
  logic              illegal;
  logic              accept;
  logic              handshake;

  logic              out_valid_reg, out_valid_next;
  logic [31:0]       out_instr_reg, out_instr_next;
  logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
  logic              err_pulse_reg, err_pulse_next;
  logic [7:0]        err_cnt_reg, err_cnt_next;

  imm_packer u_packer (
    .fmt     (fmt),
    .opcode  (opcode),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm32   (imm32),
    .instr   (packed_instr),
    .illegal (illegal)
  );

  assign in_ready  = !clear && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_reg && out_ready;

  always_comb begin
    out_valid_next = out_valid_reg;
    out_instr_next = out_instr_reg;
    out_addr_next  = out_addr_reg;
    err_pulse_next = 1'b0;
    err_cnt_next   = err_cnt_reg;
    if (clear) begin
      // Flush wins over everything; a word dropped here never advances the address.
      out_valid_next = 1'b0;
      out_addr_next  = '0;
      err_cnt_next   = '0;
    end else begin
      if (handshake) begin
        out_valid_next = 1'b0;
        out_addr_next  = (out_addr_reg == ADDR_W'(DEPTH - 1)) ? '0 : out_addr_reg + ADDR_W'(1);
      end
      if (accept && !illegal) begin
        out_valid_next = 1'b1;
        out_instr_next = packed_instr;
      end
      if (accept && illegal) begin
        err_pulse_next = 1'b1;
        if (err_cnt_reg != 8'hFF) err_cnt_next = err_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_addr_reg  <= '0;
      err_pulse_reg <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_instr_reg <= out_instr_next;
      out_addr_reg  <= out_addr_next;
      err_pulse_reg <= err_pulse_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_addr  = out_addr_reg;
  assign err_pulse = err_pulse_reg;
  assign err_cnt   = err_cnt_reg;

endmodule
